// File: rtl/bf_dispatch.sv
// Brute-force search dispatcher: splits a BCD candidate range into chunks,
// feeds them to NCH worker channels and collects the first match.
module bf_dispatch #(
    parameter int NCH          = 4,
    parameter int DIGITS       = 8,
    parameter int CHUNK_DIGITS = 4,
    parameter int CYC_PER_MS   = 100000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [4*DIGITS-1:0]     range_low,
    input  logic [4*DIGITS-1:0]     range_high,
    output logic                    busy,
    output logic                    done,
    output logic                    found,
    output logic [4*DIGITS-1:0]     pass,
    output logic [31:0]             elapsed_ms,
    output logic [NCH-1:0]          w_start,
    output logic [NCH*4*DIGITS-1:0] w_low,
    output logic [NCH*4*DIGITS-1:0] w_high,
    output logic                    w_abort,
    input  logic [NCH-1:0]          w_done,
    input  logic [NCH-1:0]          w_found,
    input  logic [NCH*4*DIGITS-1:0] w_pass
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CYC_PER_MS - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DISPATCH = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;
    localparam logic [1:0] S_FINISH   = 2'd3;

    logic [1:0]     state;
    logic [W-1:0]   ptr;
    logic [W-1:0]   hi_r;
    logic           exhausted;
    logic [NCH-1:0] ch_busy;
    logic [PW-1:0]  presc;

    logic [W-1:0]   chunk_hi_raw;
    logic [W-1:0]   chunk_hi;
    logic [W-1:0]   ptr_nxt;
    logic           ptr_carry;
    logic [NCH-1:0] hit;
    logic           hit_any;
    logic           idle_any;
    logic [IW-1:0]  hit_idx;
    logic [IW-1:0]  issue_idx;
    logic [NCH-1:0] issue_vec;
    logic           accept;
    logic           do_issue;

    function automatic logic [W-1:0] force_nines(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int d = 0; d < CHUNK_DIGITS; d++) r[4*d +: 4] = 4'h9;
        return r;
    endfunction

    // Clears the chunk digits and BCD-increments the rest; MSB is carry-out.
    function automatic logic [W:0] bump_upper(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (d < CHUNK_DIGITS) begin
                r[4*d +: 4] = 4'h0;
            end else if (c) begin
                if (r[4*d +: 4] == 4'h9) begin
                    r[4*d +: 4] = 4'h0;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'h1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    always_comb begin
        chunk_hi_raw         = force_nines(ptr);
        chunk_hi             = (chunk_hi_raw > hi_r) ? hi_r : chunk_hi_raw;
        {ptr_carry, ptr_nxt} = bump_upper(ptr);
        hit       = w_done & w_found & ch_busy;
        hit_any   = |hit;
        idle_any  = ~&ch_busy;
        hit_idx   = '0;
        issue_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (hit[k])      hit_idx   = IW'(k);
            if (!ch_busy[k]) issue_idx = IW'(k);
        end
        accept    = (state == S_IDLE) && start;
        // A hit arriving this cycle suppresses any further issue.
        do_issue  = (state == S_DISPATCH) && !exhausted && !hit_any && idle_any;
        issue_vec = do_issue ? (NCH'(1) << issue_idx) : '0;
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_FINISH);
    assign w_abort = (state == S_FLUSH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            hi_r       <= '0;
            exhausted  <= 1'b0;
            ch_busy    <= '0;
            presc      <= '0;
            found      <= 1'b0;
            pass       <= '0;
            elapsed_ms <= '0;
            w_start    <= '0;
            w_low      <= '0;
            w_high     <= '0;
        end else begin
            w_start <= issue_vec;
            ch_busy <= (ch_busy & ~w_done) | issue_vec;

            if (accept) begin
                ptr        <= range_low;
                hi_r       <= range_high;
                exhausted  <= (range_low > range_high);
                found      <= 1'b0;
                pass       <= '0;
                elapsed_ms <= '0;
                presc      <= '0;
            end else if (state != S_IDLE) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    if (elapsed_ms != 32'hFFFF_FFFF) elapsed_ms <= elapsed_ms + 32'd1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end

            if (do_issue) begin
                w_low[issue_idx*W +: W]  <= ptr;
                w_high[issue_idx*W +: W] <= chunk_hi;
                ptr                      <= ptr_nxt;
                if (ptr_carry || (ptr_nxt > hi_r)) exhausted <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) state <= S_DISPATCH;
                end
                S_DISPATCH: begin
                    if (hit_any) begin
                        found <= 1'b1;
                        pass  <= w_pass[hit_idx*W +: W];
                        state <= S_FLUSH;
                    end else if (exhausted && (ch_busy == '0)) begin
                        state <= S_FINISH;
                    end
                end
                S_FLUSH: begin
                    if (ch_busy == '0) state <= S_FINISH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
